// File: rtl/alu_result_stage.sv
// ALU result/writeback stage: owns HI/LO, serves MFHI/MFLO, queues GPR writes in a 2-entry FIFO.
// Optional macro HILO_BYPASS_EN: hi_o/lo_o forward an accepted HILO write in its accept cycle.
`timescale 1ns/1ps
module alu_result_stage #(
   parameter int DEPTH = 2,
   parameter int AW    = 5
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          in_valid_i,
   output logic          in_ready_o,
   input  logic [1:0]    kind_i,
   input  logic [63:0]   aluout_i,
   input  logic [AW-1:0] dst_i,
   output logic          wb_valid_o,
   input  logic          wb_ready_i,
   output logic [AW-1:0] wb_addr_o,
   output logic [31:0]   wb_data_o,
   output logic [31:0]   hi_o,
   output logic [31:0]   lo_o
);

   localparam logic [1:0] KIND_GPR  = 2'd0;
   localparam logic [1:0] KIND_HILO = 2'd1;
   localparam logic [1:0] KIND_MFHI = 2'd2;
   localparam logic [1:0] KIND_MFLO = 2'd3;
   localparam logic [1:0] FULL      = 2'(DEPTH);

   logic [1:0]    count_q, count_d;
   logic          head_q, tail_q;
   logic          in_ready_q;
   logic [31:0]   hi_q, lo_q;
   logic [AW-1:0] addr_q [2];
   logic [31:0]   data_q [2];

   logic          accept, push, pop;
   logic [31:0]   push_data;

   assign accept     = in_valid_i & in_ready_q;
   assign push       = accept & (kind_i != KIND_HILO) & (dst_i != '0);
   assign wb_valid_o = (count_q != 2'd0);
   assign pop        = wb_valid_o & wb_ready_i;
   assign in_ready_o = in_ready_q;

   // MFHI/MFLO read the registers, i.e. the value before any same-cycle HILO write
   always_comb begin
      push_data = aluout_i[31:0];
      case (kind_i)
         KIND_MFHI: push_data = hi_q;
         KIND_MFLO: push_data = lo_q;
         default:   push_data = aluout_i[31:0];
      endcase
   end

   always_comb begin
      count_d = count_q;
      if (push && !pop)
         count_d = count_q + 2'd1;
      else if (pop && !push)
         count_d = count_q - 2'd1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q    <= 2'd0;
         head_q     <= 1'b0;
         tail_q     <= 1'b0;
         in_ready_q <= 1'b1;
         hi_q       <= '0;
         lo_q       <= '0;
      end else begin
         count_q    <= count_d;
         in_ready_q <= (count_d < FULL);
         if (push)
            tail_q <= ~tail_q;
         if (pop)
            head_q <= ~head_q;
         if (accept && kind_i == KIND_HILO) begin
            hi_q <= aluout_i[63:32];
            lo_q <= aluout_i[31:0];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         addr_q[tail_q] <= dst_i;
         data_q[tail_q] <= push_data;
      end
   end

   // Storage is not reset; outputs are gated so an empty FIFO presents zeros
   assign wb_addr_o = wb_valid_o ? addr_q[head_q] : '0;
   assign wb_data_o = wb_valid_o ? data_q[head_q] : '0;

`ifdef HILO_BYPASS_EN
   assign hi_o = (accept && kind_i == KIND_HILO) ? aluout_i[63:32] : hi_q;
   assign lo_o = (accept && kind_i == KIND_HILO) ? aluout_i[31:0]  : lo_q;
`else
   assign hi_o = hi_q;
   assign lo_o = lo_q;
`endif

   logic unused_kind;
   assign unused_kind = (kind_i == KIND_GPR);

endmodule
